uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART 8N1 transmitter; serialises one byte per go/done handshake onto tx.
//  Mirrors the existing UART receiver's handshake (go in, done out, wait for go low).
//  Sits between the CPU's memory-mapped UART register and the board tx pin.
// PARAMETERS
//  CLK_FREQ   66_000_000  clk frequency in Hz
//  BAUD_RATE  9600        line rate; BIT_TIME = CLK_FREQ / BAUD_RATE (integer, >= 1)
// PORTS
//  clk    in   1  system clock; all logic on rising edge
//  rst_n  in   1  reset, synchronous, active-low
//  data   in   8  byte to send; sampled only on the accept cycle
//  go     in   1  request; held high by the CPU until done seen
//  tx     out  1  serial line, idle high
//  done   out  1  frame fully sent; held until go low
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): state=IDLE, tx=1, done=0, shift reg=0, counters=0.
//  - Reset mid-frame aborts immediately: tx=1 after the reset edge, no partial frame resumes.
//  - States: IDLE, START_BIT, DATA_BITS, [PARITY_BIT], STOP_BIT, WAIT_GO_LOW.
//  - IDLE: tx=1. If go=1 at edge N: latch data into shift reg, bit_count=0,
//    bit_counter=BIT_TIME-1, -> START_BIT; tx=0 from edge N+1 (1-cycle latency).
//  - Each bit occupies exactly BIT_TIME cycles. bit_counter counts down; at 0 it reloads BIT_TIME-1
//    and the next bit is driven.
//  - START_BIT: tx=0 -> DATA_BITS.
//  - DATA_BITS: tx=data[0..7], LSB first; after bit 7 -> STOP_BIT (or PARITY_BIT).
//  - STOP_BIT: tx=1 for BIT_TIME cycles, then done<=1 and -> WAIT_GO_LOW.
//    done rises at edge N+1+10*BIT_TIME (11*BIT_TIME with parity).
//  - WAIT_GO_LOW: tx=1. When go=0: done<=0 and -> IDLE. Earliest next accept is the following edge.
//  - go never restarts a frame while one is in progress.
//    go dropped mid-frame is ignored; the frame completes, done pulses for exactly 1 cycle.
//  - data changes after accept have no effect (byte held in internal register).
//  - tx is a registered output: no glitches, no combinational path from go/data.
//  - BIT_TIME==1: every bit lasts one cycle; counter width = max(1, $clog2(BIT_TIME)).
//  - bit_count width $clog2(9); state width fits 6 states; no counter wrap beyond reload values.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: even parity bit (XOR of the 8 data bits) sent for BIT_TIME cycles
//    in PARITY_BIT between bit 7 and the stop bit; frame = 11 bit-times (8E1).
//  Undefined: no PARITY_BIT state; frame = 10 bit-times (8N1).
//  Port list identical in both builds.
// TESTING (CLK_FREQ=4, BAUD_RATE=1 -> BIT_TIME=4 unless stated)
//  1. rst_n=0 two cycles, go=0 -> tx=1, done=0; stays so 20 cycles after release.
//  2. data=0x55, go=1 at edge 0 -> tx=0 at edges 1..4, then 1,0,1,0,1,0,1,0 each 4 cycles,
//     stop=1 edges 37..40, done=1 at edge 41; go=0 -> done=0 next edge.
//  3. go held high 100 cycles after done -> exactly one frame sent, done stays 1, tx stays 1.
//  4. data=0xA3 accepted, then data=0xFF and go=0 at edge 10 -> 0xA3 fully sent,
//     done=1 for exactly one cycle.
//  5. rst_n=0 at edge 15 mid-frame -> tx=1 from edge 16, done=0, next go sends a clean full frame.
//  6. BIT_TIME=1, back-to-back 0x00/0xFF with go toggled on done -> 10-cycle frames, correct bits.
//     With UART_TX_PARITY_EN: 0x07 -> parity bit 1; 0x55 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one byte per go/done handshake, serialised LSB first on tx.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit before stop); default is 8N1.
module uart_tx #(
    parameter int CLK_FREQ  = 66_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       go,
    output logic       tx,
    output logic       done
);

    localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int CW       = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(BIT_TIME - 1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [3:0]    LAST_BIT   = 4'd7;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_BIT   = 3'd1,
        DATA_BITS   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY_BIT  = 3'd3,
`endif
        STOP_BIT    = 3'd4,
        WAIT_GO_LOW = 3'd5
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   bit_counter_r;
    logic [3:0]      bit_count_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            done_r;
    logic            tx_next_s;
    logic            done_next_s;
    logic            bit_tick_s;
`ifdef UART_TX_PARITY_EN
    logic            parity_r;
`endif

    assign bit_tick_s = (bit_counter_r == CNT_ZERO);
    assign tx         = tx_r;
    assign done       = done_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bit timing counter, bit index and shift register; the byte is captured only on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_counter_r <= CNT_ZERO;
            bit_count_r   <= 4'd0;
            shift_r       <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parity_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (go) begin
                        shift_r       <= data;
                        bit_count_r   <= 4'd0;
                        bit_counter_r <= CNT_RELOAD;
`ifdef UART_TX_PARITY_EN
                        parity_r      <= even_parity(data);
`endif
                    end
                end
                DATA_BITS: begin
                    if (bit_tick_s) begin
                        bit_counter_r <= CNT_RELOAD;
                        shift_r       <= {1'b0, shift_r[7:1]};
                        bit_count_r   <= bit_count_r + 4'd1;
                    end else begin
                        bit_counter_r <= bit_counter_r - CNT_ONE;
                    end
                end
                WAIT_GO_LOW: begin
                    bit_counter_r <= CNT_ZERO;
                end
                default: begin
                    if (bit_tick_s) begin
                        bit_counter_r <= CNT_RELOAD;
                    end else begin
                        bit_counter_r <= bit_counter_r - CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (go) next_state_s = START_BIT;
                else    next_state_s = IDLE;
            end
            START_BIT: begin
                if (bit_tick_s) next_state_s = DATA_BITS;
                else            next_state_s = START_BIT;
            end
            DATA_BITS: begin
                if (bit_tick_s && (bit_count_r == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    next_state_s = PARITY_BIT;
`else
                    next_state_s = STOP_BIT;
`endif
                end else begin
                    next_state_s = DATA_BITS;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_tick_s) next_state_s = STOP_BIT;
                else            next_state_s = PARITY_BIT;
            end
`endif
            STOP_BIT: begin
                if (bit_tick_s) next_state_s = WAIT_GO_LOW;
                else            next_state_s = STOP_BIT;
            end
            WAIT_GO_LOW: begin
                if (!go) next_state_s = IDLE;
                else     next_state_s = WAIT_GO_LOW;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode; done drops on the same edge that sees go low after done was shown
    always_comb begin
        tx_next_s   = 1'b1;
        done_next_s = 1'b0;
        case (state_r)
            START_BIT: tx_next_s = 1'b0;
            DATA_BITS: tx_next_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: tx_next_s = parity_r;
`endif
            default:   tx_next_s = 1'b1;
        endcase
        if (state_r == WAIT_GO_LOW) begin
            if (done_r && !go) done_next_s = 1'b0;
            else               done_next_s = 1'b1;
        end else begin
            done_next_s = 1'b0;
        end
    end

    // Registered outputs keep tx and done glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_r   <= 1'b1;
            done_r <= 1'b0;
        end else begin
            tx_r   <= tx_next_s;
            done_r <= done_next_s;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: BIT_TIME=4 instance plus a BIT_TIME=1 instance.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       go0 = 1'b0;
    logic       tx0;
    logic       done0;
    logic [7:0] data1 = 8'h00;
    logic       go1 = 1'b0;
    logic       tx1;
    logic       done1;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(4), .BAUD_RATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .data(data0), .go(go0), .tx(tx0), .done(done0)
    );

    uart_tx #(.CLK_FREQ(1), .BAUD_RATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data(data1), .go(go1), .tx(tx1), .done(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Sends byte b on instance sel; edge 0 is the accept edge. Optionally drops go (and
    // scrambles data) before edge drop_at, or returns just before edge stop_at.
    task automatic run_frame(input bit sel, input logic [7:0] b, input int bt,
                             input int drop_at, input int stop_at);
        logic [10:0] fr;
        logic        otx;
        logic        odone;
        fr      = 11'h7FF;
        fr[0]   = 1'b0;
        fr[8:1] = b;
`ifdef UART_TX_PARITY_EN
        fr[9]   = ^b;
`endif
        if (sel) begin data1 = b; go1 = 1'b1; end
        else     begin data0 = b; go0 = 1'b1; end
        step();
        otx   = sel ? tx1 : tx0;
        odone = sel ? done1 : done0;
        chk($sformatf("latency tx b=%h", b), otx, 1'b1);
        chk($sformatf("latency done b=%h", b), odone, 1'b0);
        for (int e = 1; e <= NB * bt + 1; e++) begin
            if (e == stop_at) return;
            if (e == drop_at) begin
                if (sel) begin go1 = 1'b0; data1 = 8'hFF; end
                else     begin go0 = 1'b0; data0 = 8'hFF; end
            end
            step();
            otx   = sel ? tx1 : tx0;
            odone = sel ? done1 : done0;
            if (e <= NB * bt) begin
                chk($sformatf("tx b=%h e%0d", b, e), otx, fr[(e - 1) / bt]);
                chk($sformatf("done low b=%h e%0d", b, e), odone, 1'b0);
            end else begin
                chk($sformatf("done high b=%h", b), odone, 1'b1);
                chk($sformatf("tx idle at done b=%h", b), otx, 1'b1);
            end
        end
    endtask

    initial begin
        // 1: reset, then idle line
        step();
        step();
        chk("reset tx", tx0, 1'b1);
        chk("reset done", done0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle tx", tx0, 1'b1);
            chk("idle done", done0, 1'b0);
        end

        // 2 and 3: 0x55, go held long after done
        run_frame(1'b0, 8'h55, 4, -1, -1);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("held done", done0, 1'b1);
            chk("held tx", tx0, 1'b1);
        end
        go0 = 1'b0;
        step();
        chk("done release", done0, 1'b0);
        step();
        chk("no restart tx", tx0, 1'b1);

        // 4: go dropped and data changed mid-frame
        run_frame(1'b0, 8'hA3, 4, 10, -1);
        step();
        chk("single-cycle done", done0, 1'b0);
        chk("post pulse tx", tx0, 1'b1);
        step();
        chk("no second frame tx", tx0, 1'b1);

        // 5: reset at edge 15 aborts, then a clean frame
        run_frame(1'b0, 8'h3C, 4, -1, 15);
        rst_n = 1'b0;
        go0   = 1'b0;
        step();
        chk("abort tx", tx0, 1'b1);
        chk("abort done", done0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("after abort tx", tx0, 1'b1);
        step();
        chk("after abort tx2", tx0, 1'b1);
        run_frame(1'b0, 8'h96, 4, -1, -1);
        go0 = 1'b0;
        step();
        chk("clean frame release", done0, 1'b0);

        // 6: BIT_TIME=1 back-to-back frames
        run_frame(1'b1, 8'h00, 1, -1, -1);
        go1 = 1'b0;
        step();
        chk("bt1 release 00", done1, 1'b0);
        run_frame(1'b1, 8'hFF, 1, -1, -1);
        go1 = 1'b0;
        step();
        chk("bt1 release ff", done1, 1'b0);
`ifdef UART_TX_PARITY_EN
        run_frame(1'b1, 8'h07, 1, -1, -1);
        go1 = 1'b0;
        step();
        chk("bt1 release 07", done1, 1'b0);
        run_frame(1'b1, 8'h55, 1, -1, -1);
        go1 = 1'b0;
        step();
        chk("bt1 release 55", done1, 1'b0);
`endif
        step();
        chk("final idle tx1", tx1, 1'b1);
        chk("final idle tx0", tx0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
